// File: rtl/controller.sv
// controller: multi-cycle control FSM sequencing decode, execute, memory and writeback
module controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       op,
    input  logic       zero,
    output logic [7:0] ir,
    output logic [3:0] state,
    output logic       busy,
    output logic       done,
    output logic       halted,
    output logic [3:0] alu_op,
    output logic [1:0] src_a,
    output logic [1:0] src_b,
    output logic [1:0] dst,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       pc_load
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, DECODE = 4'd1, EXEC = 4'd2, WB = 4'd3, MEM_RD = 4'd4,
        MEM_WR = 4'd5, BRANCH = 4'd6, DONE = 4'd7, HALT = 4'd8
    } state_t;
    state_t cur, nxt;
    logic branch_taken;
    logic [3:0] cls;
    logic taken;
    assign cls = ir[7:4];
    assign taken = cls == 4'hD || zero;
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= IDLE;
            ir <= 8'h00;
            branch_taken <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == IDLE && op) ir <= opcode;
            branch_taken <= cur == BRANCH && taken;
        end
    end
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:   nxt = op ? DECODE : IDLE;
            DECODE: nxt = cls <= 4'h9 ? EXEC : cls <= 4'hB ? MEM_RD : cls == 4'hC ? MEM_WR :
                          cls <= 4'hE ? BRANCH : HALT;
            EXEC:   nxt = cls == 4'h0 ? DONE : WB;
            WB:     nxt = DONE;
            MEM_RD: nxt = WB;
            MEM_WR: nxt = DONE;
            BRANCH: nxt = DONE;
            DONE:   nxt = IDLE;
            default: nxt = HALT;
        endcase
    end
    assign state    = cur;
    assign busy     = cur != IDLE && cur != HALT;
    assign done     = cur == DONE;
    assign halted   = cur == HALT;
    // memory and branch states address through the rs field instead of rd
    assign src_a    = !busy ? 2'd0 :
                      (cur == MEM_WR || cur == BRANCH || (cur == MEM_RD && cls == 4'hB)) ? ir[1:0] : ir[3:2];
    assign src_b    = !busy ? 2'd0 : cur == MEM_WR ? ir[3:2] : ir[1:0];
    assign dst      = busy ? ir[3:2] : 2'd0;
    assign alu_op   = (cur == EXEC || (cur == WB && cls <= 4'h9)) ? cls : 4'h0;
    assign reg_we   = cur == WB;
    assign wb_sel   = cur == WB && cls >= 4'hA;
    assign mem_rd   = cur == MEM_RD;
    assign mem_wr   = cur == MEM_WR;
    assign addr_sel = (cur == MEM_RD && cls == 4'hB) || cur == MEM_WR;
    assign pc_inc   = (cur == MEM_RD && cls == 4'hA) || (cur == DONE && !branch_taken);
    assign pc_load  = cur == BRANCH && taken;
endmodule

// File: tb/tb_controller.sv
// tb_controller: instruction-level model of the control FSM checked every cycle
module tb_controller;
    logic clk = 1'b0, reset = 1'b1, op = 1'b0, zero = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic [7:0] ir;
    logic [3:0] state, alu_op;
    logic [1:0] src_a, src_b, dst;
    logic busy, done, halted, reg_we, wb_sel, mem_rd, mem_wr, addr_sel, pc_inc, pc_load;

    always #5 clk = ~clk;

    controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .zero(zero),
        .ir(ir), .state(state), .busy(busy), .done(done), .halted(halted),
        .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .dst(dst),
        .reg_we(reg_we), .wb_sel(wb_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .pc_inc(pc_inc), .pc_load(pc_load)
    );

    typedef struct packed {
        logic [3:0] state;
        logic [7:0] ir;
        logic busy, done, halted;
        logic [3:0] alu_op;
        logic [1:0] src_a, src_b, dst;
        logic reg_we, wb_sel, mem_rd, mem_wr, addr_sel, pc_inc, pc_load;
    } vec_t;

    vec_t act, cur;
    vec_t q[$];
    logic [7:0] m_ir;
    int errors = 0, checks = 0;
    int n_we, n_rd, n_wr, n_ld, n_inc;
    int seq_alu[10] = '{1, 2, 3, 7, 0, 1, 2, 3, 7, 0};

    assign act = {state, ir, busy, done, halted, alu_op, src_a, src_b, dst,
                  reg_we, wb_sel, mem_rd, mem_wr, addr_sel, pc_inc, pc_load};

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    function automatic vec_t base(input logic [3:0] code);
        vec_t v;
        v = '0;
        v.state = code;
        v.ir = m_ir;
        v.busy = 1'b1;
        v.src_a = m_ir[3:2];
        v.src_b = m_ir[1:0];
        v.dst = m_ir[3:2];
        return v;
    endfunction

    function automatic vec_t fin(input logic inc);
        vec_t v;
        v = base(4'd7);
        v.done = 1'b1;
        v.pc_inc = inc;
        return v;
    endfunction

    // expected cycle-by-cycle output program for one instruction
    task automatic build(input logic [7:0] opc, input logic z);
        vec_t v;
        logic [3:0] c;
        logic t;
        m_ir = opc;
        c = opc[7:4];
        cur = base(4'd1);
        if (c == 4'h0) begin
            q.push_back(base(4'd2));
            q.push_back(fin(1'b1));
        end else if (c <= 4'h9) begin
            v = base(4'd2); v.alu_op = c; q.push_back(v);
            v = base(4'd3); v.alu_op = c; v.reg_we = 1'b1; q.push_back(v);
            q.push_back(fin(1'b1));
        end else if (c <= 4'hB) begin
            v = base(4'd4); v.mem_rd = 1'b1;
            if (c == 4'hA) v.pc_inc = 1'b1;
            else begin v.addr_sel = 1'b1; v.src_a = opc[1:0]; end
            q.push_back(v);
            v = base(4'd3); v.reg_we = 1'b1; v.wb_sel = 1'b1; q.push_back(v);
            q.push_back(fin(1'b1));
        end else if (c == 4'hC) begin
            v = base(4'd5); v.mem_wr = 1'b1; v.addr_sel = 1'b1;
            v.src_a = opc[1:0]; v.src_b = opc[3:2]; q.push_back(v);
            q.push_back(fin(1'b1));
        end else if (c <= 4'hE) begin
            t = c == 4'hD || z;
            v = base(4'd6); v.src_a = opc[1:0]; v.pc_load = t; q.push_back(v);
            q.push_back(fin(!t));
        end else begin
            v = '0; v.state = 4'd8; v.ir = opc; v.halted = 1'b1; q.push_back(v);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            q.delete();
            m_ir = 8'h00;
            cur = '0;
        end else if (cur.state == 4'd8) begin
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.state == 4'd0 && op) begin
            build(opcode, zero);
        end else begin
            cur = '0;
            cur.ir = m_ir;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #5;
        chk("cycle", act, cur);
        n_we += int'(reg_we);
        n_rd += int'(mem_rd);
        n_wr += int'(mem_wr);
        n_ld += int'(pc_load);
        n_inc += int'(pc_inc);
    endtask

    task automatic run_instr(input logic [7:0] opc, input logic z, output int lat);
        opcode = opc;
        zero = z;
        op = 1'b1;
        n_we = 0; n_rd = 0; n_wr = 0; n_ld = 0; n_inc = 0;
        step();
        op = 1'b0;
        lat = 1;
        while (state != 4'd0 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_we", 32'(reg_we), 0);
        reset = 1'b0;
        opcode = 8'h1D;
        op = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("alu_seq", 32'(state), seq_alu[i]);
            chk("alu_ir", 32'(ir), 32'h1D);
            if (i == 2) begin
                chk("wb_we", 32'(reg_we), 1);
                chk("wb_dst", 32'(dst), 3);
                chk("wb_sel", 32'(wb_sel), 0);
                chk("wb_alu", 32'(alu_op), 1);
                chk("wb_srcb", 32'(src_b), 1);
            end
            if (i == 3) begin
                chk("done", 32'(done), 1);
                chk("done_inc", 32'(pc_inc), 1);
            end
        end
        op = 1'b0;
        run_instr(8'hA4, 1'b0, lat);
        chk("ldi_lat", lat, 5); chk("ldi_we", n_we, 1); chk("ldi_rd", n_rd, 1); chk("ldi_inc", n_inc, 2);
        run_instr(8'hB9, 1'b0, lat);
        chk("ld_lat", lat, 5); chk("ld_rd", n_rd, 1); chk("ld_inc", n_inc, 1);
        run_instr(8'hC6, 1'b0, lat);
        chk("st_lat", lat, 4); chk("st_wr", n_wr, 1); chk("st_we", n_we, 0); chk("st_inc", n_inc, 1);
        run_instr(8'hE2, 1'b1, lat);
        chk("jz1_lat", lat, 4); chk("jz1_ld", n_ld, 1); chk("jz1_inc", n_inc, 0);
        run_instr(8'hE2, 1'b0, lat);
        chk("jz0_ld", n_ld, 0); chk("jz0_inc", n_inc, 1);
        run_instr(8'hD3, 1'b0, lat);
        chk("jmp_ld", n_ld, 1); chk("jmp_inc", n_inc, 0);
        run_instr(8'h00, 1'b0, lat);
        chk("nop_lat", lat, 4); chk("nop_inc", n_inc, 1);
        run_instr(8'h6E, 1'b0, lat);
        chk("not_lat", lat, 5); chk("not_we", n_we, 1);
        opcode = 8'hF0;
        op = 1'b1;
        step();
        op = 1'b0;
        step();
        chk("halt_state", 32'(state), 8);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        opcode = 8'h1D;
        op = 1'b1;
        repeat (3) step();
        chk("halt_stay", 32'(state), 8);
        chk("halt_ir", 32'(ir), 32'hF0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        op = 1'b0;
        chk("unhalt_state", 32'(state), 0);
        chk("unhalt_ir", 32'(ir), 0);
        opcode = 8'h1D;
        op = 1'b1;
        step();
        op = 1'b0;
        step();
        step();
        chk("mid_wb_we", 32'(reg_we), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_we", 32'(reg_we), 0);
        chk("mid_rst_ir", 32'(ir), 0);
        n_we = 0;
        repeat (4) step();
        chk("mid_rst_no_we", n_we, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
